// File: rtl/op2_pkg.sv
// op2_pkg: shared types and constants for the operand-2 fetch block.
// Optional feature macro: OP2_REG_SHIFT_EN (register-register shift form).
package op2_pkg;

    // Fetch sequencer states; RD_RS exists only when shift-by-register is built.
    typedef enum logic [2:0] {
        IDLE,
`ifdef OP2_REG_SHIFT_EN
        RD_RS,
`endif
        RD_RM,
        CAP,
        ISSUE
    } op2_state_e;

    // Operand-2 encoding classes.
    typedef enum logic [1:0] {
        FORM_IMM,
        FORM_REG_IMM,
        FORM_REG_REG,
        FORM_UNDEF
    } op2_form_e;

    // Shift-type encodings.
    localparam logic [1:0] SHIFT_LSL = 2'b00;
    localparam logic [1:0] SHIFT_LSR = 2'b01;
    localparam logic [1:0] SHIFT_ASR = 2'b10;
    localparam logic [1:0] SHIFT_ROR = 2'b11;

endpackage

// File: rtl/op2_decode.sv
// op2_decode: purely combinational classification of a data-processing
// instruction word into its operand-2 form and fields.
// Optional feature macro: OP2_REG_SHIFT_EN (without it, shift-by-register
// encodings are classified as undefined).
module op2_decode
    import op2_pkg::*;
(
    input  logic [31:0] ir_i,
    output op2_form_e   form_o,
    output logic [3:0]  rm_o,
    output logic [3:0]  rs_o,
    output logic [1:0]  shType_o,
    output logic [7:0]  imm8_o,
    output logic [4:0]  shImm_o
);

    logic unusedBits;

    assign rm_o       = ir_i[3:0];
    assign rs_o       = ir_i[11:8];
    assign shType_o   = ir_i[6:5];
    assign imm8_o     = ir_i[7:0];
    assign shImm_o    = ir_i[11:7];
    assign unusedBits = ^{ir_i[31:26], ir_i[24:12]};

    // Classify the encoding: immediate, shift-by-immediate, shift-by-register or undefined.
    always_comb begin
        form_o = FORM_UNDEF;
        if (ir_i[25]) begin
            form_o = FORM_IMM;
        end else if (!ir_i[4]) begin
            form_o = FORM_REG_IMM;
        end
`ifdef OP2_REG_SHIFT_EN
        else if (!ir_i[7]) begin
            form_o = FORM_REG_REG;
        end
`endif
    end

endmodule

// File: rtl/operand2_fetch.sv
// operand2_fetch: sequences the register-file reads needed by operand 2 and
// presents value/amount/type to the barrel shifter over a valid/ready link.
// Optional feature macro: OP2_REG_SHIFT_EN (shift-by-register support).
module operand2_fetch
    import op2_pkg::*;
#(
    parameter int RF_AW = 4
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      ir,
    output logic             busy,
    output logic             rf_rd_en,
    output logic [RF_AW-1:0] rf_addr,
    input  logic [31:0]      rf_data,
    output logic [31:0]      sh_operand,
    output logic [4:0]       sh_amount,
    output logic [1:0]       sh_type,
    output logic             sh_rrx,
    output logic             sh_big,
    output logic             sh_valid,
    input  logic             sh_ready,
    output logic             undef
);

    op2_state_e  state_q, state_d;
    op2_form_e   decForm;
    logic [3:0]  decRm, decRs;
    logic [1:0]  decType;
    logic [7:0]  decImm8;
    logic [4:0]  decShImm;
    logic        accept;

    logic [3:0]  rmAddr_q;
    logic [31:0] operand_q;
    logic [4:0]  amount_q;
    logic [1:0]  type_q;
    logic        rrx_q, big_q, undef_q;

`ifdef OP2_REG_SHIFT_EN
    logic [3:0]  rsAddr_q;
    logic        regReg_q;
`else
    logic        unusedRs;
    assign unusedRs = ^decRs;
`endif

    op2_decode u_decode (
        .ir_i     (ir),
        .form_o   (decForm),
        .rm_o     (decRm),
        .rs_o     (decRs),
        .shType_o (decType),
        .imm8_o   (decImm8),
        .shImm_o  (decShImm)
    );

    assign accept     = (state_q == IDLE) && start;
    assign busy       = (state_q != IDLE);
    assign sh_valid   = (state_q == ISSUE);
    assign sh_operand = operand_q;
    assign sh_amount  = amount_q;
    assign sh_type    = type_q;
    assign sh_rrx     = rrx_q;
    assign sh_big     = big_q;
    assign undef      = undef_q;

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: pick the read sequence from the decoded form, then walk it to ISSUE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (decForm)
                        FORM_IMM:     state_d = ISSUE;
                        FORM_REG_IMM: state_d = RD_RM;
`ifdef OP2_REG_SHIFT_EN
                        FORM_REG_REG: state_d = RD_RS;
`endif
                        default:      state_d = IDLE;
                    endcase
                end
            end
`ifdef OP2_REG_SHIFT_EN
            RD_RS:   state_d = RD_RM;
`endif
            RD_RM:   state_d = CAP;
            CAP:     state_d = ISSUE;
            ISSUE:   if (sh_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Register-file read strobe and address driven from the current read state.
    always_comb begin
        rf_rd_en = 1'b0;
        rf_addr  = '0;
        case (state_q)
`ifdef OP2_REG_SHIFT_EN
            RD_RS: begin
                rf_rd_en = 1'b1;
                rf_addr  = RF_AW'(rsAddr_q);
            end
`endif
            RD_RM: begin
                rf_rd_en = 1'b1;
                rf_addr  = RF_AW'(rmAddr_q);
            end
            default: ;
        endcase
    end

    // Shifter-side registers: loaded at accept and by the read captures, frozen through ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            rmAddr_q  <= '0;
            operand_q <= '0;
            amount_q  <= '0;
            type_q    <= '0;
            rrx_q     <= 1'b0;
            big_q     <= 1'b0;
            undef_q   <= 1'b0;
`ifdef OP2_REG_SHIFT_EN
            rsAddr_q  <= '0;
            regReg_q  <= 1'b0;
`endif
        end else begin
            undef_q <= 1'b0;
            if (accept) begin
`ifdef OP2_REG_SHIFT_EN
                regReg_q <= (decForm == FORM_REG_REG);
`endif
                case (decForm)
                    FORM_IMM: begin
                        operand_q <= {24'b0, decImm8};
                        amount_q  <= {decRs, 1'b0};
                        type_q    <= SHIFT_ROR;
                        rrx_q     <= 1'b0;
                        big_q     <= 1'b0;
                    end
                    FORM_REG_IMM: begin
                        rmAddr_q <= decRm;
                        amount_q <= decShImm;
                        type_q   <= decType;
                        rrx_q    <= (decShImm == 5'd0) && (decType == SHIFT_ROR);
                        big_q    <= (decShImm == 5'd0) &&
                                    ((decType == SHIFT_LSR) || (decType == SHIFT_ASR));
                    end
`ifdef OP2_REG_SHIFT_EN
                    FORM_REG_REG: begin
                        rmAddr_q <= decRm;
                        rsAddr_q <= decRs;
                        amount_q <= 5'd0;
                        type_q   <= decType;
                        rrx_q    <= 1'b0;
                        big_q    <= 1'b0;
                    end
`endif
                    default: undef_q <= 1'b1;
                endcase
            end
`ifdef OP2_REG_SHIFT_EN
            if ((state_q == RD_RM) && regReg_q) begin
                amount_q <= rf_data[4:0];
                big_q    <= (rf_data[7:5] != 3'd0);
            end
`endif
            if (state_q == CAP) begin
                operand_q <= rf_data;
            end
        end
    end

endmodule

// File: tb/tb_operand2_fetch.sv
// tb_operand2_fetch: randomized, self-checking bench for operand2_fetch with a
// behavioural register file and a cycle-timeline reference model.
module tb_operand2_fetch;

    localparam int RF_AW = 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic [31:0]      ir;
    logic             busy;
    logic             rf_rd_en;
    logic [RF_AW-1:0] rf_addr;
    logic [31:0]      rf_data;
    logic [31:0]      sh_operand;
    logic [4:0]       sh_amount;
    logic [1:0]       sh_type;
    logic             sh_rrx;
    logic             sh_big;
    logic             sh_valid;
    logic             sh_ready;
    logic             undef;

    operand2_fetch #(.RF_AW(RF_AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ir         (ir),
        .busy       (busy),
        .rf_rd_en   (rf_rd_en),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .sh_operand (sh_operand),
        .sh_amount  (sh_amount),
        .sh_type    (sh_type),
        .sh_rrx     (sh_rrx),
        .sh_big     (sh_big),
        .sh_valid   (sh_valid),
        .sh_ready   (sh_ready),
        .undef      (undef)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    logic [31:0]      regs [16];
    logic             pendEn   = 1'b0;
    logic [RF_AW-1:0] pendAddr = '0;

    // Reference-model results for the instruction under test.
    int          expForm;
    int          expLat;
    logic [3:0]  expRs, expRm;
    logic [31:0] expOperand;
    logic [4:0]  expAmount;
    logic [1:0]  expType;
    logic        expRrx, expBig;

    // Advance one cycle; the register file answers a strobe one cycle later, otherwise junk.
    task automatic stepCycle();
        @(posedge clk);
        #1;
        rf_data  = pendEn ? regs[pendAddr] : $urandom();
        pendEn   = rf_rd_en;
        pendAddr = rf_addr;
    endtask

    task automatic randomizeRegs();
        for (int i = 0; i < 16; i++) regs[i] = $urandom();
    endtask

    // Behavioural model: form, first-valid latency and shifter fields from the encoding rules.
    task automatic modelInstr(input logic [31:0] i);
        logic [31:0] rsVal;
        expRs      = i[11:8];
        expRm      = i[3:0];
        expRrx     = 1'b0;
        expBig     = 1'b0;
        expType    = i[6:5];
        expOperand = regs[i[3:0]];
        expAmount  = 5'd0;
        if (i[25]) begin
            expForm    = 0;
            expLat     = 1;
            expOperand = {24'd0, i[7:0]};
            expAmount  = 5'(2 * i[11:8]);
            expType    = 2'b11;
        end else if (!i[4]) begin
            expForm   = 1;
            expLat    = 3;
            expAmount = i[11:7];
            expBig    = (i[11:7] == 5'd0) && ((i[6:5] == 2'd1) || (i[6:5] == 2'd2));
            expRrx    = (i[11:7] == 5'd0) && (i[6:5] == 2'd3);
        end
`ifdef OP2_REG_SHIFT_EN
        else if (!i[7]) begin
            expForm   = 2;
            expLat    = 4;
            rsVal     = regs[i[11:8]];
            expAmount = 5'(rsVal % 32);
            expBig    = (rsVal % 256) >= 32;
        end
`endif
        else begin
            expForm = 3;
            expLat  = 0;
        end
    endtask

    // Issue one instruction at the current cycle and check every cycle until the block is idle again.
    task automatic runInstr(input logic [31:0] instr, input int stall, input bit pulseStart);
        int               tEnd;
        logic             eBusy, eValid, eUndef, eRd;
        logic [RF_AW-1:0] eAddr;
        modelInstr(instr);
        tEnd = (expForm == 3) ? 2 : expLat + stall + 1;
        for (int t = 0; t <= tEnd; t++) begin
            if (t > 0) stepCycle();
            if (t == 0) begin
                start = 1'b1;
                ir    = instr;
            end else if (pulseStart && expForm != 3 && t >= expLat && t <= expLat + stall) begin
                start = 1'b1;
                ir    = $urandom() | 32'h0200_0000;
            end else begin
                start = 1'b0;
                ir    = $urandom();
            end
            sh_ready = (expForm == 3 || t < expLat) ? 1'($urandom()) : (t >= expLat + stall);

            eBusy  = (expForm != 3) && (t >= 1) && (t <= expLat + stall);
            eValid = (expForm != 3) && (t >= expLat) && (t >= 1) && (t <= expLat + stall);
            eUndef = (expForm == 3) && (t == 1);
            eRd    = 1'b0;
            eAddr  = '0;
            if (expForm == 1 && t == 1) begin eRd = 1'b1; eAddr = expRm; end
            if (expForm == 2 && t == 1) begin eRd = 1'b1; eAddr = expRs; end
            if (expForm == 2 && t == 2) begin eRd = 1'b1; eAddr = expRm; end

            checkCount++;
            if ({busy, sh_valid, undef, rf_rd_en, rf_addr} !== {eBusy, eValid, eUndef, eRd, eAddr}) begin
                $display("[TB] FAIL ctrl ir=%h t=%0d: busy/valid/undef/rd/addr got %b/%b/%b/%b/%h expected %b/%b/%b/%b/%h",
                         instr, t, busy, sh_valid, undef, rf_rd_en, rf_addr, eBusy, eValid, eUndef, eRd, eAddr);
            end else begin
                passCount++;
            end

            if (eValid) begin
                checkCount++;
                if ({sh_operand, sh_amount, sh_type, sh_rrx, sh_big} !== {expOperand, expAmount, expType, expRrx, expBig}) begin
                    $display("[TB] FAIL shdata ir=%h t=%0d: op/amt/type/rrx/big got %h/%0d/%b/%b/%b expected %h/%0d/%b/%b/%b",
                             instr, t, sh_operand, sh_amount, sh_type, sh_rrx, sh_big,
                             expOperand, expAmount, expType, expRrx, expBig);
                end else begin
                    passCount++;
                end
            end
        end
    endtask

    // Reset clears everything and wins over a simultaneous start.
    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b1;
        ir       = 32'hE3A0_04FF;
        sh_ready = 1'b0;
        rf_data  = '0;
        stepCycle();
        stepCycle();
        checkCount++;
        if ({busy, rf_rd_en, sh_valid, undef, sh_rrx, sh_big, rf_addr, sh_operand, sh_amount, sh_type} !== '0) begin
            $display("[TB] FAIL reset: busy/rd/valid/undef/rrx/big/addr/op/amt/type got %b/%b/%b/%b/%b/%b/%h/%h/%0d/%b expected all zero",
                     busy, rf_rd_en, sh_valid, undef, sh_rrx, sh_big, rf_addr, sh_operand, sh_amount, sh_type);
        end else begin
            passCount++;
        end
        start = 1'b0;
        reset = 1'b0;
        stepCycle();
    endtask

    task automatic test_immediate();
        runInstr(32'hE3A0_04FF, 0, 1'b0);
        runInstr(32'hE3A0_0F01, 1, 1'b0);
    endtask

    task automatic test_reg_imm();
        regs[2] = 32'hF234_5678;
        runInstr(32'hE1A0_0102, 0, 1'b0);
        runInstr(32'hE1A0_0023, 0, 1'b0);
        runInstr(32'hE1A0_0043, 0, 1'b0);
        runInstr(32'hE1A0_0063, 0, 1'b0);
        runInstr(32'hE1A0_0003, 1, 1'b0);
    endtask

    task automatic test_reg_reg();
        regs[3] = 32'h0000_0028;
        regs[2] = 32'hF234_5678;
        runInstr(32'hE1A0_0312, 0, 1'b0);
        regs[3] = 32'hFFFF_FF1F;
        runInstr(32'hE1A0_0352, 1, 1'b0);
    endtask

    task automatic test_undef();
        runInstr(32'hE1A0_0092, 0, 1'b0);
        runInstr(32'hE1A0_0FF0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        runInstr(32'hE1A0_0102, 3, 1'b1);
        runInstr(32'hE3A0_04FF, 3, 1'b1);
        runInstr(32'hE1A0_0312, 3, 1'b1);
    endtask

    // Reset asserted in RD_RM drops the instruction with no later sh_valid.
    task automatic test_reset_mid();
        regs[2] = 32'hF234_5678;
        start   = 1'b1;
        ir      = 32'hE1A0_0102;
        stepCycle();
        start = 1'b0;
        checkCount++;
        if ({busy, rf_rd_en} !== 2'b11) begin
            $display("[TB] FAIL midreset_pre: busy/rd got %b/%b expected 1/1", busy, rf_rd_en);
        end else begin
            passCount++;
        end
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        checkCount++;
        if ({busy, rf_rd_en, sh_valid} !== 3'b000) begin
            $display("[TB] FAIL midreset: busy/rd/valid got %b/%b/%b expected 0/0/0", busy, rf_rd_en, sh_valid);
        end else begin
            passCount++;
        end
        for (int k = 0; k < 6; k++) begin
            sh_ready = 1'($urandom());
            stepCycle();
            checkCount++;
            if ({busy, sh_valid} !== 2'b00) begin
                $display("[TB] FAIL midreset_after c=%0d: busy/valid got %b/%b expected 0/0", k, busy, sh_valid);
            end else begin
                passCount++;
            end
        end
    endtask

    task automatic test_back_to_back();
        runInstr(32'hE1A0_0102, 0, 1'b0);
        runInstr(32'hE3A0_04FF, 0, 1'b0);
        runInstr(32'hE1A0_0312, 0, 1'b0);
        runInstr(32'hE1A0_0092, 0, 1'b0);
        runInstr(32'hE1A0_0063, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] instr;
        for (int n = 0; n < 80; n++) begin
            if (n % 10 == 0) randomizeRegs();
            instr = $urandom();
            if ($urandom_range(0, 3) == 0) instr[11:7] = 5'd0;
            runInstr(instr, $urandom_range(0, 3), 1'($urandom()));
        end
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        ir       = '0;
        sh_ready = 1'b0;
        rf_data  = '0;
        randomizeRegs();
        $display("[TB] operand2_fetch bench starting");
        test_reset();
        test_immediate();
        test_reg_imm();
        test_reg_reg();
        test_undef();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/operand2_fetch.md
OPERAND2_FETCH -- requirements
Module: operand2_fetch

Interface
REQ-001 Parameter: RF_AW, default 4, register-file address width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  instruction valid; sampled only when busy=0.
REQ-005 ir  in  32  data-processing instruction word; latched on accepted start.
REQ-006 busy  out  1  high whenever the FSM is not in IDLE.
REQ-007 rf_rd_en  out  1  register-file read strobe.
REQ-008 rf_addr  out  RF_AW  register-file read address.
REQ-009 rf_data  in  32  read data, valid the cycle after rf_rd_en.
REQ-010 sh_operand  out  32  value to shift; sh_amount  out  5  shift amount; sh_type  out  2  shift type.
REQ-011 sh_rrx  out  1  ROR #0 encodes RRX; sh_big  out  1  effective amount is ≥32.
REQ-012 sh_valid  out  1 / sh_ready  in  1  valid/ready handshake to the shifter.
REQ-013 undef  out  1  one-cycle pulse for an unsupported operand-2 encoding.

Function
REQ-014 Decode on accepted start:
- Immediate form: ir[25]=1.
- Register-immediate form: ir[25]=0, ir[4]=0.
- Register-register form: ir[25]=0, ir[4]=1, ir[7]=0.
- Undefined: ir[25]=0, ir[4]=1, ir[7]=1.
REQ-015 FSM states are IDLE, RD_RS, RD_RM, CAP, ISSUE, with these transitions out of IDLE on start:
- Immediate -> ISSUE.
- Register-immediate -> RD_RM.
- Register-register -> RD_RS.
- Undefined -> stays in IDLE; undef pulses the next cycle.
REQ-016 Remaining transitions: RD_RS->RD_RM; RD_RM->CAP; CAP->ISSUE; ISSUE->IDLE on sh_valid&&sh_ready.
REQ-017 Read strobes:
- RD_RS drives rf_rd_en=1, rf_addr=ir[11:8].
- RD_RM drives rf_rd_en=1, rf_addr=ir[3:0].
- rf_rd_en=0 in all other states.
REQ-018 Data capture: in RD_RM, rf_data is captured as the Rs value (register-register form only); in CAP, rf_data is captured as sh_operand.
REQ-019 sh_valid first asserts, counted from the start cycle (cycle 0):
- Immediate: cycle 1.
- Register-immediate: cycle 3.
- Register-register: cycle 4.
REQ-020 Immediate form outputs: sh_operand={24'b0,ir[7:0]}, sh_amount={ir[11:8],1'b0}, sh_type=ROR, sh_big=0, sh_rrx=0.
REQ-021 Register-immediate form outputs: sh_amount=ir[11:7], sh_type=ir[6:5].
- LSR or ASR with amount 0: sh_big=1, sh_amount=0.
- ROR with amount 0: sh_rrx=1.
REQ-022 Register-register form outputs: sh_type=ir[6:5], sh_amount=Rs[4:0], sh_big=(Rs[7:0]≥32); Rs[31:8] is ignored.
REQ-023 While sh_valid=1 and sh_ready=0, all sh_* outputs SHALL hold stable.
REQ-024 start is ignored while busy=1, including the ISSUE cycle that completes the handshake; this gives a minimum one-cycle bubble.
REQ-025 Shift-type encoding: LSL=00, LSR=01, ASR=10, ROR=11.

Reset
REQ-026 While reset=1, at the next edge:
- State goes to IDLE.
- busy, rf_rd_en, sh_valid, undef, sh_rrx and sh_big go to 0.
- rf_addr, sh_operand, sh_amount and sh_type go to 0.
REQ-027 Reset in any state, including mid-handshake, abandons the instruction with no sh_valid pulse; reset has priority over start.

Configuration
REQ-028 Macro OP2_REG_SHIFT_EN:
- Defined: the register-register form is supported as above.
- Undefined: the register-register form is treated as undefined (undef pulse, no RF read), and the RD_RS state and Rs capture register are not compiled.

Structure
REQ-029 Package op2_pkg holds the FSM state enum, the shift-type constants and the operand-2 form enum.
REQ-030 Combinational sub-module op2_decode classifies ir into form, Rm, Rs, type and immediate fields; operand2_fetch instantiates it once.

Verification
REQ-031 Immediate form: ir=0xE3A004FF, start -> cycle 1: sh_valid=1, sh_operand=0x000000FF, sh_amount=8, sh_type=11, no rf_rd_en.
REQ-032 Register-immediate form: ir[11:0]=0x102, rf_data=0xF2345678 -> rf_addr=2 at cycle 1; cycle 3: sh_operand=0xF2345678, sh_amount=2, sh_type=00. Also ir[11:0]=0x023 -> sh_big=1, sh_amount=0; ir[11:0]=0x063 -> sh_rrx=1.
REQ-033 Register-register form: ir[11:0]=0x312, Rs data=0x28, Rm data=0xF2345678 -> rf_addr 3 then 2; cycle 4: sh_big=1, sh_amount=8, sh_type=00. With the macro undefined -> undef pulse at cycle 1.
REQ-034 Undefined form: ir[11:0]=0x092 -> undef=1 for exactly one cycle at cycle 1; busy and rf_rd_en stay 0.
REQ-035 Backpressure: sh_ready held low 3 cycles in ISSUE -> outputs stable; start pulsed during ISSUE is ignored; IDLE follows the handshake.
REQ-036 Reset mid-operation: reset asserted in RD_RM -> next cycle busy=0, rf_rd_en=0, sh_valid=0, and no later sh_valid pulse.
